uart_frame_parser: RTL



---
 rtl/uart_frame_parser.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser behind a UART receiver: hunts HDR0 HDR1 LEN payload CHK,
// buffers and checksums the payload, then streams it out over valid/ready.
module uart_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 624960,
  parameter logic [7:0] HDR0         = 8'hAA,
  parameter logic [7:0] HDR1         = 8'h55
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         sum_q, sum_d;
  logic [7:0]         wr_ptr_q, wr_ptr_d;
  logic [7:0]         rd_ptr_q, rd_ptr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         drop_q, drop_d;
  logic [7:0]         m_data_q;

  logic [7:0]         buf_mem [MAX_LEN];
  logic               wr_en;
  logic               rd_en;
  logic [PTR_W-1:0]   rd_addr;
  logic               timed;
  logic               last_beat;

  assign timed     = (state_q == S_HDR1) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign last_beat = (state_q == S_OUTPUT) && (rd_ptr_q == len_q - 8'd1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tmo_d      = '0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = PTR_W'(rd_ptr_q + 8'd1);

    if (timed && !rx_done) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_done && rx_data == HDR0) state_d = S_HDR1;
      end
      S_HDR1: begin
        if (rx_done) begin
          if (rx_data == HDR1)      state_d = S_LEN;
          else if (rx_data != HDR0) state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (rx_done) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            len_d    = rx_data;
            sum_d    = rx_data;
            wr_ptr_d = 8'd0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done) begin
          wr_en    = 1'b1;
          sum_d    = sum_q + rx_data;
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q + 8'd1 == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_done) begin
          if (rx_data == sum_q) begin
            // Prefetch buf[0] so the first beat is presented alongside frame_ok.
            state_d  = S_OUTPUT;
            ok_d     = 1'b1;
            rd_ptr_d = 8'd0;
            rd_en    = 1'b1;
            rd_addr  = '0;
          end else begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end
        end
      end
      S_OUTPUT: begin
        if (m_ready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 8'd1;
            rd_en    = 1'b1;
          end
        end
        if (rx_done && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // A byte arriving on the terminal count takes priority over the timeout.
    if (timed && !rx_done && tmo_q == TMO_LAST) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = 2'b11;
      tmo_d      = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      len_q      <= 8'd0;
      sum_q      <= 8'd0;
      wr_ptr_q   <= 8'd0;
      rd_ptr_q   <= 8'd0;
      tmo_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      drop_q     <= 8'd0;
      m_data_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tmo_q      <= tmo_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      drop_q     <= drop_d;
      if (rd_en) m_data_q <= buf_mem[rd_addr];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) buf_mem[wr_ptr_q[PTR_W-1:0]] <= rx_data;
  end

  assign m_data    = m_data_q;
  assign m_valid   = (state_q == S_OUTPUT);
  assign m_last    = last_beat;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != S_IDLE);
  assign drop_cnt  = drop_q;

endmodule
